// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types for the bit-serial magnitude comparator.
//   state_t : FSM state (IDLE, COMPARE)
//   res_t   : 2-bit per-step result code; RES_NONE means "keep scanning".
//             The top level decodes this code into its one-hot EQ/LT/GRT flags.
// -----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    typedef logic [1:0] res_t;

    localparam res_t RES_NONE = 2'd0;
    localparam res_t RES_EQ   = 2'd1;
    localparam res_t RES_LT   = 2'd2;
    localparam res_t RES_GRT  = 2'd3;

endpackage

// File: rtl/cmp_bit_decide.sv
// -----------------------------------------------------------------------------
// cmp_bit_decide
// Combinational single-bit decision for the serial comparator.
//   a_bit, b_bit : operand bits at the current scan position
//   is_msb       : current position is the sign bit
//   signed_mode  : two's-complement compare when high
//   differ       : the two bits differ (the scan terminates at this bit)
//   a_greater    : A > B, given that the bits differ
// -----------------------------------------------------------------------------
module cmp_bit_decide (
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_msb,
    input  logic signed_mode,
    output logic differ,
    output logic a_greater
);

    assign differ = a_bit ^ b_bit;

    // A set sign bit means a negative operand, so at the MSB in signed mode
    // the operand holding the 0 is the larger one.
    assign a_greater = (is_msb && signed_mode) ? b_bit : a_bit;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
// Bit-serial MSB-first magnitude comparator with early exit on the first
// differing bit. Operands and mode are latched on an accepted start.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request a compare (sampled only in IDLE)
//   A, B         : WIDTH-bit operands
//   signed_mode  : 1 = two's-complement, 0 = unsigned
//   busy         : compare in progress
//   done         : one-cycle pulse, result flags valid
//   EQ, LT, GRT  : one-hot result, held until the next accepted start
// -----------------------------------------------------------------------------
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             LT,
    output logic             GRT
);

    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sm;
    logic [IDXW-1:0]  r_idx;

    logic             w_is_msb;
    logic             w_differ;
    logic             w_a_greater;
    res_t             w_res;

    assign w_is_msb = (r_idx == IDX_MSB);

    cmp_bit_decide u_decide (
        .a_bit       (r_a[r_idx]),
        .b_bit       (r_b[r_idx]),
        .is_msb      (w_is_msb),
        .signed_mode (r_sm),
        .differ      (w_differ),
        .a_greater   (w_a_greater)
    );

    // Outcome of the current scan step; RES_NONE keeps the scan going.
    always_comb begin
        w_res = RES_NONE;
        if (w_differ)
            w_res = w_a_greater ? RES_GRT : RES_LT;
        else if (r_idx == '0)
            w_res = RES_EQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sm    <= 1'b0;
            r_idx   <= IDX_MSB;
            busy    <= 1'b0;
            done    <= 1'b0;
            EQ      <= 1'b0;
            LT      <= 1'b0;
            GRT     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sm    <= signed_mode;
                        r_idx   <= IDX_MSB;
                        busy    <= 1'b1;
                        EQ      <= 1'b0;
                        LT      <= 1'b0;
                        GRT     <= 1'b0;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_res != RES_NONE) begin
                        EQ      <= (w_res == RES_EQ);
                        LT      <= (w_res == RES_LT);
                        GRT     <= (w_res == RES_GRT);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised, bit-serial magnitude comparator: the multi-cycle successor to the team's 3-bit combinational EQ/LT/GRT comparator. It latches two WIDTH-bit operands on a start strobe and scans them MSB-first, one bit per clock, with early termination on the first differing bit. It supports unsigned and two's-complement signed comparison. It sits beside datapath blocks that need wide compares without a wide combinational compare tree, and reports its result with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.
- IDXW, $clog2(WIDTH), bit-index counter width; derived, do not override.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a comparison; sampled only in IDLE.
- A  in  WIDTH  operand A; latched when start is accepted.
- B  in  WIDTH  operand B; latched when start is accepted.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse marking a valid result.
- EQ  out  1  A == B.
- LT  out  1  A < B.
- GRT  out  1  A > B.

## Operation
- FSM has two states: IDLE and COMPARE.
- IDLE, start=1: latch A, B and signed_mode; set idx = WIDTH-1; clear EQ/LT/GRT; go to COMPARE.
- IDLE, start=0: hold state and all outputs.
- COMPARE, each edge: examine a_q[idx] vs b_q[idx].
  - Bits differ, not the sign bit (or unsigned mode): a_q[idx]=1 sets GRT, otherwise sets LT. Go to IDLE.
  - Bits differ at idx = WIDTH-1 with signed_mode=1: the result is inverted; a_q[MSB]=1 sets LT, otherwise sets GRT.
  - Bits equal, idx > 0: decrement idx and stay in COMPARE.
  - Bits equal, idx = 0: set EQ and go to IDLE.
- done is registered and goes high together with the result flag.
- After completion, exactly one of EQ/LT/GRT is high. The flag holds until the next accepted start or reset.
- start while busy is ignored; there is no queueing.
- Changes on A, B or signed_mode after acceptance have no effect on the comparison in progress.

## Timing
- Reset values: state=IDLE, busy=0, done=0, EQ=0, LT=0, GRT=0, idx=WIDTH-1.
- Start accepted at edge E0: busy=1 after E0, and all flags read 0 from that point.
- Edge E0+j (j >= 1) examines bit WIDTH-j.
- First difference at bit i: the result is registered at edge E0+(WIDTH-i). In the cycle after that edge, done=1, busy=0 and the flag is valid.
  - Latency is WIDTH-i edges: 1 when the MSB differs, WIDTH when only bit 0 differs or the operands are equal.
- done is high for exactly one cycle and deasserts at the next edge.
- Back-to-back: start is legal in the same cycle done=1, because the FSM is already in IDLE. It is accepted at the next edge; done then drops, the flags clear and busy rises.
- Asynchronous rst mid-COMPARE forces every reset value immediately. No done pulse is produced for the aborted comparison.

## Structure
- Shared package cmp_pkg:
  - state enum typedef (IDLE, COMPARE);
  - 2-bit result encoding constants (RES_NONE, RES_EQ, RES_LT, RES_GRT), used internally to drive the one-hot flags.
- One natural sub-module, cmp_bit_decide: combinational; inputs a_bit, b_bit, is_msb, signed_mode; outputs differ, a_greater.
- Top level holds the FSM, the operand registers, the idx down-counter and the output registers.

## Test plan
- WIDTH=8, unsigned, A=0x80, B=0x7F -> GRT=1, done one cycle after the first COMPARE edge (latency 1). Same operands with signed_mode=1 -> LT=1, latency 1.
- A=B=0xA5 -> EQ=1, LT=GRT=0, latency 8. busy high for exactly 8 cycles, done high for exactly 1.
- A=0x12, B=0x13 unsigned -> LT=1, latency 8. Then A=0xF0, B=0xE0 signed -> GRT=1 (-16 > -32), latency 4.
- Pulse start for A=0x01, B=0x02 mid-comparison while busy -> ignored; the original result is unaffected. Hold start high during the done cycle -> new compare accepted, flags clear next edge.
- Assert rst 3 cycles into a compare -> busy, done, EQ, LT and GRT all 0 immediately, no done pulse. A following compare A=0x05, B=0x05 -> EQ=1.
- Random sweep, WIDTH=3 and WIDTH=16, both modes -> flags match a reference compare, exactly one flag high, latency = WIDTH - (index of first differing bit).
